// File: rtl/vx_operand_collector_pkg.sv
// Shared widths, instruction/operand bus types and FSM encoding for the
// operand collector and its bank arbiter.
package vx_operand_collector_pkg;

  localparam int NR_BITS       = 5;
  localparam int NUM_THREADS   = 2;
  localparam int XLEN          = 32;
  localparam int ISSUE_WIS_W   = 2;
  localparam int UUID_W        = 8;
  localparam int NUM_SRCS      = 3;
  localparam int DEF_NUM_BANKS = 2;

  // Row address width within one bank: {wis, rs >> log2(num_banks)}.
  function automatic int bank_addr_w(input int num_banks);
    return ISSUE_WIS_W + NR_BITS - $clog2(num_banks);
  endfunction

  typedef logic [NR_BITS-1:0]          reg_idx_t;
  typedef logic [NUM_THREADS*XLEN-1:0] reg_data_t;

  typedef enum logic [1:0] {EX_ALU, EX_LSU, EX_FPU, EX_SFU} ex_type_e;

  typedef struct packed {
    logic [UUID_W-1:0]      uuid;
    logic [ISSUE_WIS_W-1:0] wis;
    logic [NUM_THREADS-1:0] tmask;
    logic [XLEN-1:0]        pc;
    ex_type_e               ex_type;
    logic [3:0]             op_type;
    logic [2:0]             op_mod;
    logic                   wb;
    logic                   use_pc;
    logic                   use_imm;
    logic [XLEN-1:0]        imm;
    reg_idx_t               rd;
    logic                   is_mstore;
  } instr_t;

  typedef struct packed {
    instr_t              base;
    reg_idx_t            rs1;
    reg_idx_t            rs2;
    reg_idx_t            rs3;
    logic [NUM_SRCS-1:0] rs_used;  // bit 0 = rs1
  } collector_in_t;

  typedef struct packed {
    instr_t    base;
    reg_data_t rs1_data;
    reg_data_t rs2_data;
    reg_data_t rs3_data;
  } data_t;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WAIT, ST_OUT} state_e;

endpackage

// File: rtl/vx_operand_bank_arb.sv
// Combinational per-bank read selection: lowest pending operand wins each bank,
// and any other pending operand naming the same register rides on that read.
module vx_operand_bank_arb
  import vx_operand_collector_pkg::*;
#(
  parameter  int NUM_BANKS = DEF_NUM_BANKS,
  localparam int BANK_BITS = $clog2(NUM_BANKS),
  localparam int ROW_W     = bank_addr_w(NUM_BANKS)
) (
  input  logic [NUM_SRCS-1:0]                 pending,
  input  logic [NUM_SRCS-1:0][NR_BITS-1:0]    rs,
  input  logic [ISSUE_WIS_W-1:0]              wis,
  output logic [NUM_BANKS-1:0]                req_valid,
  output logic [NUM_BANKS-1:0][ROW_W-1:0]     req_addr,
  output logic [NUM_SRCS-1:0][NUM_BANKS-1:0]  served
);

  localparam reg_idx_t BANK_MASK = NR_BITS'(NUM_BANKS - 1);

  reg_idx_t [NUM_BANKS-1:0] sel;

  // NOTE: every output gets a default before the loops so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    req_valid = '0;
    req_addr  = '0;
    served    = '0;
    sel       = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = 0; i < NUM_SRCS; i++) begin
        if (!req_valid[b] && pending[i] && ((rs[i] & BANK_MASK) == NR_BITS'(b))) begin
          req_valid[b] = 1'b1;
          sel[b]       = rs[i];
        end
      end
      if (req_valid[b]) begin
        req_addr[b] = {wis, sel[b][NR_BITS-1:BANK_BITS]};
      end
      for (int j = 0; j < NUM_SRCS; j++) begin
        if (req_valid[b] && pending[j] && (rs[j] == sel[b])) begin
          served[j][b] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vx_operand_collector.sv
// Operand collector: accepts one issued instruction, reads its source operands
// from the banked GPR file over one or more rounds, then holds it for dispatch.
module vx_operand_collector
  import vx_operand_collector_pkg::*;
#(
  parameter  int NUM_BANKS   = DEF_NUM_BANKS,
  localparam int BANK_ADDR_W = bank_addr_w(NUM_BANKS)
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      in_valid,
  input  collector_in_t                             in_data,
  output logic                                      in_ready,
  output logic [NUM_BANKS-1:0]                      gpr_req_valid,
  output logic [NUM_BANKS-1:0][BANK_ADDR_W-1:0]     gpr_req_addr,
  input  logic [NUM_BANKS-1:0][NUM_THREADS*XLEN-1:0] gpr_rsp_data,
  output logic                                      out_valid,
  output data_t                                     out_data,
  input  logic                                      out_ready
);

  state_e                               state, state_n;
  collector_in_t                        instr;
  logic [NUM_SRCS-1:0]                  pending, pending_n, init_pending, served_any;
  logic [NUM_SRCS-1:0][NUM_BANKS-1:0]   served, cap_served;
  reg_data_t [NUM_SRCS-1:0]             rs_data;
  logic [NUM_BANKS-1:0]                 arb_valid;
  logic [NUM_BANKS-1:0][BANK_ADDR_W-1:0] arb_addr;
  logic                                 accept;

  vx_operand_bank_arb #(.NUM_BANKS(NUM_BANKS)) u_arb (
    .pending   (pending),
    .rs        ({instr.rs3, instr.rs2, instr.rs1}),
    .wis       (instr.base.wis),
    .req_valid (arb_valid),
    .req_addr  (arb_addr),
    .served    (served)
  );

  // Register 0 and unused operands never touch the GPR file; they stay zero.
  assign init_pending = in_data.rs_used &
                        {in_data.rs3 != '0, in_data.rs2 != '0, in_data.rs1 != '0};

  assign in_ready      = reset_n && ((state == ST_IDLE) || ((state == ST_OUT) && out_ready));
  assign accept        = in_valid && in_ready;
  assign gpr_req_valid = (state == ST_READ) ? arb_valid : '0;
  assign gpr_req_addr  = arb_addr;
  assign out_valid     = (state == ST_OUT);
  assign out_data      = '{base: instr.base, rs1_data: rs_data[0],
                           rs2_data: rs_data[1], rs3_data: rs_data[2]};

  always_comb begin
    for (int i = 0; i < NUM_SRCS; i++) served_any[i] = |served[i];
  end

  always_comb begin
    state_n   = state;
    pending_n = pending;
    case (state)
      ST_READ: begin
        pending_n = pending & ~served_any;
        if (pending_n == '0) state_n = ST_WAIT;
      end
      ST_WAIT: state_n = ST_OUT;
      ST_OUT:  if (out_ready) state_n = ST_IDLE;
      default: ;
    endcase
    if (accept) begin
      pending_n = init_pending;
      state_n   = (init_pending == '0) ? ST_OUT : ST_READ;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      pending    <= '0;
      instr      <= '0;
      cap_served <= '0;
      // NOTE: operand data registers are reset too, so nothing stale from a
      // dropped instruction can reach out_data.
      rs_data    <= '0;
    end else begin
      state      <= state_n;
      pending    <= pending_n;
      cap_served <= (state == ST_READ) ? served : '0;
      if (accept) begin
        instr   <= in_data;
        rs_data <= '0;
      end
      for (int i = 0; i < NUM_SRCS; i++) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          if (cap_served[i][b]) rs_data[i] <= gpr_rsp_data[b];
        end
      end
    end
  end

endmodule

// File: tb/tb_vx_operand_collector.sv
// Directed bench for vx_operand_collector: GPR model answers one cycle after
// each request, expected operands and rows are hand-derived per step.
module tb_vx_operand_collector;
  import vx_operand_collector_pkg::*;

  localparam int NB = 2;
  localparam int AW = bank_addr_w(NB);

  logic                        clk = 1'b0;
  logic                        reset_n;
  logic                        in_valid;
  collector_in_t               in_data;
  logic                        in_ready;
  logic [NB-1:0]               gpr_req_valid;
  logic [NB-1:0][AW-1:0]       gpr_req_addr;
  logic [NB-1:0][NUM_THREADS*XLEN-1:0] gpr_rsp_data;
  logic                        out_valid;
  data_t                       out_data;
  logic                        out_ready;

  int n_cmp = 0;
  int n_err = 0;

  vx_operand_collector #(.NUM_BANKS(NB)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .gpr_req_valid (gpr_req_valid),
    .gpr_req_addr  (gpr_req_addr),
    .gpr_rsp_data  (gpr_rsp_data),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready)
  );

  always #5 clk = ~clk;

  function automatic reg_data_t gpr_model(input int b, input logic [AW-1:0] row);
    return {32'h2000_0000 + 32'(b) * 32'h100 + 32'(row),
            32'h1000_0000 + 32'(b) * 32'h100 + 32'(row)};
  endfunction

  function automatic reg_data_t exp_rd(input logic [1:0] wis, input reg_idx_t rs);
    logic [AW-1:0] row;
    row = {wis, rs[4:1]};
    return gpr_model(int'(rs[0]), row);
  endfunction

  // GPR file: requests seen during a cycle are answered in the next cycle;
  // unrequested banks return junk that must never be captured.
  logic [NB-1:0]         rq_v;
  logic [NB-1:0][AW-1:0] rq_a;
  always @(negedge clk) begin
    rq_v = gpr_req_valid;
    rq_a = gpr_req_addr;
  end
  always @(posedge clk) begin
    #1;
    for (int b = 0; b < NB; b++)
      gpr_rsp_data[b] = rq_v[b] ? gpr_model(b, rq_a[b]) : {2{32'hBAD0_0000 | 32'(b)}};
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic collector_in_t mk(input logic [7:0] uuid, input logic [1:0] wis,
                                       input reg_idx_t rs1, input reg_idx_t rs2,
                                       input reg_idx_t rs3, input logic [2:0] used);
    collector_in_t d;
    d                = '0;
    d.base.uuid      = uuid;
    d.base.wis       = wis;
    d.base.tmask     = uuid[1:0] | 2'b01;
    d.base.pc        = 32'h8000_0000 + (32'(uuid) << 2);
    d.base.ex_type   = ex_type_e'(uuid[1:0]);
    d.base.op_type   = uuid[3:0];
    d.base.op_mod    = uuid[2:0];
    d.base.wb        = uuid[0];
    d.base.use_pc    = uuid[1];
    d.base.use_imm   = uuid[2];
    d.base.imm       = 32'hCAFE_0000 | 32'(uuid);
    d.base.rd        = uuid[4:0];
    d.base.is_mstore = uuid[0];
    d.rs1            = rs1;
    d.rs2            = rs2;
    d.rs3            = rs3;
    d.rs_used        = used;
    return d;
  endfunction

  // Called at a negedge with the DUT ready; returns at the negedge of T+1.
  task automatic accept(input string tag, input collector_in_t d);
    in_data  = d;
    in_valid = 1'b1;
    #1 check({tag, ".in_ready"}, 256'(in_ready), 256'(1'b1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input collector_in_t d,
                           input reg_data_t e1, input reg_data_t e2, input reg_data_t e3);
    check({tag, ".out_valid"}, 256'(out_valid), 256'(1'b1));
    check({tag, ".base"},      256'(out_data.base), 256'(d.base));
    check({tag, ".rs1_data"},  256'(out_data.rs1_data), 256'(e1));
    check({tag, ".rs2_data"},  256'(out_data.rs2_data), 256'(e2));
    check({tag, ".rs3_data"},  256'(out_data.rs3_data), 256'(e3));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    collector_in_t d1, d2, d3, d4, d5, d6, d7, d8;
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst.in_ready",  256'(in_ready),      256'(1'b0));
    check("rst.out_valid", 256'(out_valid),     256'(1'b0));
    check("rst.req_valid", 256'(gpr_req_valid), 256'(2'b00));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 check("rel.in_ready", 256'(in_ready), 256'(1'b1));
    @(negedge clk);

    // rs1=5 -> bank1 row 0x12, rs2=6 -> bank0 row 0x13: one round.
    d1 = mk(8'd1, 2'd1, 5'd5, 5'd6, 5'd9, 3'b011);
    accept("t1", d1);
    check("t1.req_valid", 256'(gpr_req_valid),   256'(2'b11));
    check("t1.addr1",     256'(gpr_req_addr[1]), 256'(6'h12));
    check("t1.addr0",     256'(gpr_req_addr[0]), 256'(6'h13));
    check("t1.in_ready",  256'(in_ready),        256'(1'b0));
    check("t1.early_ov",  256'(out_valid),       256'(1'b0));
    @(negedge clk);
    check("t1.wait_req",  256'(gpr_req_valid),   256'(2'b00));
    check("t1.wait_ov",   256'(out_valid),       256'(1'b0));
    @(negedge clk);
    check_out("t1", d1, exp_rd(2'd1, 5'd5), exp_rd(2'd1, 5'd6), '0);
    check("t1.out_ready_pass", 256'(in_ready), 256'(1'b1));
    @(negedge clk);
    check("t1.idle_ov", 256'(out_valid), 256'(1'b0));

    // rs1=3, rs2=5, rs3=7 all on bank1: three rounds, rows 1,2,3.
    d2 = mk(8'd2, 2'd0, 5'd3, 5'd5, 5'd7, 3'b111);
    accept("t2", d2);
    for (int r = 0; r < 3; r++) begin
      check($sformatf("t2.r%0d.req_valid", r), 256'(gpr_req_valid),   256'(2'b10));
      check($sformatf("t2.r%0d.addr1", r),     256'(gpr_req_addr[1]), 256'(r + 1));
      check($sformatf("t2.r%0d.ov", r),        256'(out_valid),       256'(1'b0));
      @(negedge clk);
    end
    check("t2.wait_req", 256'(gpr_req_valid), 256'(2'b00));
    check("t2.wait_ov",  256'(out_valid),     256'(1'b0));
    @(negedge clk);
    check_out("t2", d2, exp_rd(2'd0, 5'd3), exp_rd(2'd0, 5'd5), exp_rd(2'd0, 5'd7));
    @(negedge clk);

    // rs1=rs2=4 merges into a single bank0 read of row 0x22.
    d3 = mk(8'd3, 2'd2, 5'd4, 5'd4, 5'd0, 3'b011);
    accept("t3", d3);
    check("t3.req_valid", 256'(gpr_req_valid),   256'(2'b01));
    check("t3.addr0",     256'(gpr_req_addr[0]), 256'(6'h22));
    @(negedge clk);
    check("t3.wait_req",  256'(gpr_req_valid),   256'(2'b00));
    @(negedge clk);
    check_out("t3", d3, exp_rd(2'd2, 5'd4), exp_rd(2'd2, 5'd4), '0);
    @(negedge clk);

    // rs1=0 used, others unused: no reads, output next cycle, all zero.
    d4 = mk(8'd4, 2'd1, 5'd0, 5'd3, 5'd7, 3'b001);
    accept("t4", d4);
    check("t4.req_valid", 256'(gpr_req_valid), 256'(2'b00));
    check_out("t4", d4, '0, '0, '0);
    @(negedge clk);

    // Backpressure: hold out_ready low for 10 cycles with the next instruction waiting.
    out_ready = 1'b0;
    d5 = mk(8'd5, 2'd3, 5'd9, 5'd10, 5'd0, 3'b011);
    d6 = mk(8'd6, 2'd3, 5'd2, 5'd0, 5'd0, 3'b001);
    accept("t5", d5);
    check("t5.req_valid", 256'(gpr_req_valid), 256'(2'b11));
    check("t5.addr1",     256'(gpr_req_addr[1]), 256'(6'h34));
    check("t5.addr0",     256'(gpr_req_addr[0]), 256'(6'h35));
    @(negedge clk);
    @(negedge clk);
    in_data  = d6;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check_out($sformatf("t5.hold%0d", c), d5, exp_rd(2'd3, 5'd9), exp_rd(2'd3, 5'd10), '0);
      check($sformatf("t5.hold%0d.in_ready", c), 256'(in_ready), 256'(1'b0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check("t5.release_ready", 256'(in_ready), 256'(1'b1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("t6.req_valid", 256'(gpr_req_valid),   256'(2'b01));
    check("t6.addr0",     256'(gpr_req_addr[0]), 256'(6'h31));
    check("t6.ov",        256'(out_valid),       256'(1'b0));
    @(negedge clk);
    @(negedge clk);
    check_out("t6", d6, exp_rd(2'd3, 5'd2), '0, '0);
    @(negedge clk);

    // Reset during round 2 of a three-round read drops the instruction.
    d7 = mk(8'd7, 2'd1, 5'd3, 5'd5, 5'd7, 3'b111);
    accept("t7", d7);
    check("t7.r0.addr1", 256'(gpr_req_addr[1]), 256'(6'h11));
    @(negedge clk);
    check("t7.r1.req_valid", 256'(gpr_req_valid),   256'(2'b10));
    check("t7.r1.addr1",     256'(gpr_req_addr[1]), 256'(6'h12));
    #1 reset_n = 1'b0;
    #1;
    check("t7.rst.req_valid", 256'(gpr_req_valid), 256'(2'b00));
    check("t7.rst.out_valid", 256'(out_valid),     256'(1'b0));
    check("t7.rst.in_ready",  256'(in_ready),      256'(1'b0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("t7.rel.in_ready",  256'(in_ready),      256'(1'b1));
    check("t7.rel.out_valid", 256'(out_valid),     256'(1'b0));
    @(negedge clk);
    check("t7.post.out_valid", 256'(out_valid),     256'(1'b0));
    check("t7.post.req_valid", 256'(gpr_req_valid), 256'(2'b00));
    d8 = mk(8'd8, 2'd0, 5'd0, 5'd0, 5'd0, 3'b000);
    accept("t8", d8);
    check("t8.req_valid", 256'(gpr_req_valid), 256'(2'b00));
    check_out("t8", d8, '0, '0, '0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
